serial_mag_compare: RTL and testbench

- Sequential N-bit magnitude comparator built around the existing 2-bit comparator slice. It sits directly upstream of that slice and consumes what the slice produces.
- It latches two WIDTH-bit operands, presents them to the slice MSB-first, two bits per cycle, and reads back the slice's gt/lt/eq flags.
- It resolves the wide comparison from the first non-equal slice and returns one one-hot result through a valid/ready handshake.

---
 rtl/serial_mag_compare.sv | 154 +++++++++++++++
 tb/tb_serial_mag_compare.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare.sv
// rtl/serial_mag_compare.sv - MSB-first serial magnitude comparator driving an external 2-bit slice
// Optional early exit on first deciding slice: define SERIAL_CMP_EARLY_EXIT_EN.
module serial_mag_compare #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [1:0]       slice_a,
   output logic [1:0]       slice_b,
   input  logic             slice_gt,
   input  logic             slice_lt,
   input  logic             slice_eq,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_gt,
   output logic             res_lt,
   output logic             res_eq,
   output logic             res_err,
   output logic             busy
);

   localparam int NSLICE = WIDTH / 2;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    w_idx_nx;
   logic             r_primed;
   logic             r_decided;
   logic             r_gt;
   logic             r_lt;
   logic             r_err;
   logic [1:0]       r_slice_a;
   logic [1:0]       r_slice_b;
   logic             r_res_gt;
   logic             r_res_lt;
   logic             r_res_eq;
   logic             r_res_err;
   logic             w_onehot;
   logic             w_hit;
   logic             w_exit;

   // The first SCAN cycle only loads the slice registers; flags are trusted once primed.
   assign w_onehot = (slice_gt ^ slice_lt ^ slice_eq) & ~(slice_gt & slice_lt & slice_eq);
   assign w_hit    = (r_state == S_SCAN) & r_primed & ~r_decided & w_onehot & (slice_gt | slice_lt);
   assign w_idx_nx = r_idx - 1'b1;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign w_exit = r_primed & ((r_idx == '0) | w_hit);
`else
   assign w_exit = r_primed & (r_idx == '0);
`endif

   assign start_ready = (r_state == S_IDLE);
   assign res_valid   = (r_state == S_DONE);
   assign busy        = (r_state != S_IDLE);
   assign slice_a     = r_slice_a;
   assign slice_b     = r_slice_b;
   assign res_gt      = r_res_gt;
   assign res_lt      = r_res_lt;
   assign res_eq      = r_res_eq;
   assign res_err     = r_res_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start_valid) w_next = S_SCAN;
         S_SCAN:  if (w_exit)      w_next = S_DONE;
         S_DONE:  if (res_ready)   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_idx     <= '0;
         r_primed  <= 1'b0;
         r_decided <= 1'b0;
         r_gt      <= 1'b0;
         r_lt      <= 1'b0;
         r_err     <= 1'b0;
         r_slice_a <= 2'b00;
         r_slice_b <= 2'b00;
         r_res_gt  <= 1'b0;
         r_res_lt  <= 1'b0;
         r_res_eq  <= 1'b0;
         r_res_err <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_valid) begin
                  r_a       <= a_in;
                  r_b       <= b_in;
                  r_idx     <= IW'(NSLICE - 1);
                  r_primed  <= 1'b0;
                  r_decided <= 1'b0;
                  r_gt      <= 1'b0;
                  r_lt      <= 1'b0;
                  r_err     <= 1'b0;
                  r_res_gt  <= 1'b0;
                  r_res_lt  <= 1'b0;
                  r_res_eq  <= 1'b0;
                  r_res_err <= 1'b0;
               end
            end
            S_SCAN: begin
               if (!r_primed) begin
                  r_slice_a <= r_a[{r_idx, 1'b0} +: 2];
                  r_slice_b <= r_b[{r_idx, 1'b0} +: 2];
                  r_primed  <= 1'b1;
               end else begin
                  if (!w_onehot) r_err <= 1'b1;
                  if (w_hit) begin
                     r_decided <= 1'b1;
                     r_gt      <= slice_gt;
                     r_lt      <= slice_lt;
                  end
                  if (w_exit) begin
                     // Results are published only here so no partial answer is ever visible.
                     r_res_gt  <= r_gt | (w_hit & slice_gt);
                     r_res_lt  <= r_lt | (w_hit & slice_lt);
                     r_res_eq  <= ~(r_decided | w_hit);
                     r_res_err <= r_err | ~w_onehot;
                     r_slice_a <= 2'b00;
                     r_slice_b <= 2'b00;
                  end else begin
                     r_idx     <= w_idx_nx;
                     r_slice_a <= r_a[{w_idx_nx, 1'b0} +: 2];
                     r_slice_b <= r_b[{w_idx_nx, 1'b0} +: 2];
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mag_compare.sv
// tb/tb_serial_mag_compare.sv - self-checking bench for serial_mag_compare with a behavioural 2-bit slice
module tb_serial_mag_compare;

   localparam int WIDTH  = 8;
   localparam int NSLICE = WIDTH / 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start_valid = 1'b0;
   logic             start_ready;
   logic [WIDTH-1:0] a_in = '0;
   logic [WIDTH-1:0] b_in = '0;
   logic [1:0]       slice_a;
   logic [1:0]       slice_b;
   logic             slice_gt;
   logic             slice_lt;
   logic             slice_eq;
   logic             res_valid;
   logic             res_ready = 1'b0;
   logic             res_gt;
   logic             res_lt;
   logic             res_eq;
   logic             res_err;
   logic             busy;
   logic             fault_on = 1'b0;

   always #5 clk = ~clk;

   // Comparator slice; fault_on forces gt and eq together.
   assign slice_gt = fault_on | (slice_a > slice_b);
   assign slice_lt = ~fault_on & (slice_a < slice_b);
   assign slice_eq = fault_on | (slice_a == slice_b);

   serial_mag_compare #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .a_in(a_in), .b_in(b_in),
      .slice_a(slice_a), .slice_b(slice_b),
      .slice_gt(slice_gt), .slice_lt(slice_lt), .slice_eq(slice_eq),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_gt(res_gt), .res_lt(res_lt), .res_eq(res_eq), .res_err(res_err),
      .busy(busy)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] seq [NSLICE];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      for (int i = NSLICE - 1; i >= 0; i--)
         if (((a >> (2 * i)) & 3) != ((b >> (2 * i)) & 3)) return (NSLICE - i) + 1;
`endif
      return NSLICE + 1;
   endfunction

   task automatic run_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold,
                          input bit fault, output logic gt, output logic lt, output logic eq,
                          output logic err, output int lat);
      @(negedge clk);
      a_in = a; b_in = b; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      a_in = ~a; b_in = ~b;
      chk("err_cleared_on_start", res_err, 0);
      chk("busy_after_start", busy, 1);
      lat = 0;
      while (!res_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (!res_valid && lat <= NSLICE) seq[lat-1] = {slice_a, slice_b};
         fault_on = fault && (lat == 2);
      end
      fault_on = 1'b0;
      chk("res_valid_in_time", res_valid, 1);
      gt = res_gt; lt = res_lt; eq = res_eq; err = res_err;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         start_valid = 1'b1; a_in = WIDTH'($urandom); b_in = WIDTH'($urandom);
         chk("hold_valid", res_valid, 1);
         chk("hold_result", {res_gt, res_lt, res_eq, res_err}, {gt, lt, eq, err});
         chk("hold_start_ready", start_ready, 0);
      end
      @(negedge clk);
      start_valid = 1'b0; res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("accept_valid_drops", res_valid, 0);
      chk("accept_idle", start_ready, 1);
      chk("accept_result_held", {res_gt, res_lt, res_eq, res_err}, {gt, lt, eq, err});
   endtask

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             gt;
      logic             lt;
      logic             eq;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic gt, lt, eq, err;
      int   lat;
      logic [WIDTH-1:0] ra, rb;
      logic [3:0] exp_seq [NSLICE];

      vecs[0] = '{8'hC3, 8'hC3, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'hC0, 8'h3F, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0};

      #2;
      chk("reset_outputs", {start_ready, res_valid, res_gt, res_lt, res_eq, res_err, busy}, 7'b1000000);
      chk("reset_slices", {slice_a, slice_b}, 4'b0000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_cmp(vecs[i].a, vecs[i].b, 0, 1'b0, gt, lt, eq, err, lat);
         chk($sformatf("vec%0d_result", i), {gt, lt, eq, err}, {vecs[i].gt, vecs[i].lt, vecs[i].eq, 1'b0});
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].a, vecs[i].b)));
      end

      exp_seq[0] = 4'b0000; exp_seq[1] = 4'b0000; exp_seq[2] = 4'b0000; exp_seq[3] = 4'b0110;
      run_cmp(8'h01, 8'h02, 0, 1'b0, gt, lt, eq, err, lat);
      for (int k = 0; k < NSLICE; k++) chk($sformatf("lsb_seq%0d", k), seq[k], exp_seq[k]);

      run_cmp(8'h10, 8'h20, 4, 1'b0, gt, lt, eq, err, lat);
      chk("bp_result", {gt, lt, eq}, 3'b010);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_start_not_queued", busy, 0);
      end

      run_cmp(8'h44, 8'h44, 0, 1'b1, gt, lt, eq, err, lat);
      chk("fault_result", {gt, lt, eq, err}, 4'b0011);
      run_cmp(8'h44, 8'h44, 0, 1'b0, gt, lt, eq, err, lat);
      chk("fault_cleared", {gt, lt, eq, err}, 4'b0010);

      @(negedge clk);
      a_in = 8'h5A; b_in = 8'h5B; start_valid = 1'b1;
      @(posedge clk); #1;
      start_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midscan_reset_outputs", {start_ready, res_valid, res_gt, res_lt, res_eq, res_err, busy}, 7'b1000000);
      chk("midscan_reset_slices", {slice_a, slice_b}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_reset_idle", {start_ready, res_valid, busy}, 3'b100);
      end

      for (int r = 0; r < 40; r++) begin
         ra = WIDTH'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
         if ($urandom_range(0, 3) == 0) rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
         run_cmp(ra, rb, $urandom_range(0, 2), 1'b0, gt, lt, eq, err, lat);
         chk($sformatf("rand%0d_%0h_%0h", r, ra, rb), {gt, lt, eq, err},
             {ra > rb, ra < rb, ra == rb, 1'b0});
         chk($sformatf("rand%0d_latency", r), 32'(lat), 32'(exp_lat(ra, rb)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
